// File: rtl/affine3_op2_feed_if.sv
// rtl/affine3_op2_feed_if.sv - stream, bank and sum signals of the affine3 op2 feed block
interface affine3_op2_feed_if;
  logic         in_valid;
  logic         in_ready;
  logic [9:0]   in_data;
  logic         in_last;
  logic [159:0] bank_out;
  logic [13:0]  sum_in;
  logic         out_valid;
  logic         out_ready;
  logic [13:0]  out_data;

  modport slave (
    input  in_valid, in_data, in_last, sum_in, out_ready,
    output in_ready, bank_out, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, in_last, sum_in, out_ready,
    input  in_ready, bank_out, out_valid, out_data
  );
endinterface

// File: rtl/affine3_op2_feed.sv
// rtl/affine3_op2_feed.sv - 16-slot operand bank feeding the affine3 adder; AFFINE3_OP2_FEED_ZEROPAD_EN enables in_last zero-padding
module affine3_op2_feed #(
  parameter int ADD_LATENCY = 0
) (
  input logic               clk,
  input logic               reset,
  affine3_op2_feed_if.slave bus
);
  localparam int WCNT_W = (ADD_LATENCY > 0) ? $clog2(ADD_LATENCY + 1) : 1;

  typedef enum logic [1:0] {FILL, WAIT, HOLD} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic [WCNT_W-1:0] wcnt;
  logic [9:0]        bank [16];
  logic              in_xfer;
  logic              out_xfer;
  logic              frame_end;

  assign in_xfer  = (state == FILL) && bus.in_valid && bus.in_ready;
  assign out_xfer = bus.out_valid && bus.out_ready;

`ifdef AFFINE3_OP2_FEED_ZEROPAD_EN
  assign frame_end = in_xfer && ((cnt == 4'd15) || bus.in_last);
`else
  logic unused_in_last;
  assign unused_in_last = bus.in_last;
  assign frame_end = in_xfer && (cnt == 4'd15);
`endif

  for (genvar g = 0; g < 16; g++) begin : g_slot
    assign bus.bank_out[10*g +: 10] = bank[g];
  end

  // in_ready is registered alongside state so it never depends on out_ready
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FILL;
      cnt           <= 4'd0;
      wcnt          <= '0;
      bus.in_ready  <= 1'b1;
      bus.out_valid <= 1'b0;
      bus.out_data  <= 14'd0;
      for (int i = 0; i < 16; i++) bank[i] <= 10'd0;
    end else begin
      case (state)
        FILL: begin
          if (in_xfer) begin
            for (int i = 0; i < 16; i++) begin
              if (4'(i) == cnt) begin
                bank[i] <= bus.in_data;
`ifdef AFFINE3_OP2_FEED_ZEROPAD_EN
              end else if (bus.in_last && (4'(i) > cnt)) begin
                bank[i] <= 10'd0;
`endif
              end
            end
            if (frame_end) begin
              cnt          <= 4'd0;
              wcnt         <= WCNT_W'(ADD_LATENCY);
              state        <= WAIT;
              bus.in_ready <= 1'b0;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end
        WAIT: begin
          if (wcnt != '0) begin
            wcnt <= wcnt - 1'b1;
          end else begin
            bus.out_data  <= bus.sum_in;
            bus.out_valid <= 1'b1;
            state         <= HOLD;
          end
        end
        HOLD: begin
          if (out_xfer) begin
            bus.out_valid <= 1'b0;
            bus.in_ready  <= 1'b1;
            state         <= FILL;
          end
        end
        default: begin
          state         <= FILL;
          bus.in_ready  <= 1'b1;
          bus.out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_affine3_op2_feed.sv
// tb/tb_affine3_op2_feed.sv - directed bench for affine3_op2_feed at ADD_LATENCY 0 and 2
module tb_affine3_op2_feed;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   in_valid = '0;
  logic [1:0]   in_last = '0;
  logic [1:0]   out_ready = 2'b11;
  logic [9:0]   in_data [2];
  logic [1:0]   in_ready_o;
  logic [1:0]   out_valid_o;
  logic [13:0]  out_data_o [2];
  logic [159:0] bank_o [2];
  logic [13:0]  s1, s2;
  int passed = 0;
  int total = 0;

  affine3_op2_feed_if if0 ();
  affine3_op2_feed_if if1 ();

  function automatic logic [13:0] add16(input logic [159:0] b);
    logic [13:0] s;
    s = '0;
    for (int i = 0; i < 16; i++) s = s + 14'(b[10*i +: 10]);
    return s;
  endfunction

  assign if0.in_valid  = in_valid[0];
  assign if0.in_last   = in_last[0];
  assign if0.in_data   = in_data[0];
  assign if0.out_ready = out_ready[0];
  assign if0.sum_in    = add16(if0.bank_out);
  assign if1.in_valid  = in_valid[1];
  assign if1.in_last   = in_last[1];
  assign if1.in_data   = in_data[1];
  assign if1.out_ready = out_ready[1];
  assign if1.sum_in    = s2;

  always_ff @(posedge clk) begin
    s1 <= add16(if1.bank_out);
    s2 <= s1;
  end

  assign in_ready_o    = {if1.in_ready, if0.in_ready};
  assign out_valid_o   = {if1.out_valid, if0.out_valid};
  assign out_data_o[0] = if0.out_data;
  assign out_data_o[1] = if1.out_data;
  assign bank_o[0]     = if0.bank_out;
  assign bank_o[1]     = if1.bank_out;

  affine3_op2_feed #(.ADD_LATENCY(0)) dut0 (.clk(clk), .reset(reset), .bus(if0.slave));
  affine3_op2_feed #(.ADD_LATENCY(2)) dut2 (.clk(clk), .reset(reset), .bus(if1.slave));

  task automatic put(input int d, input logic [9:0] data, input logic last, input int gap);
    int k;
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    in_last[d]  = last;
    k = 0;
    while (!in_ready_o[d] && k < 100) begin
      @(negedge clk);
      k++;
    end
    if (k >= 100) begin
      total++;
      $display("FAIL put_timeout dut%0d: in_ready=%0b, expected 1", d, in_ready_o[d]);
    end
    @(negedge clk);
    in_valid[d] = 1'b0;
    in_last[d]  = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_out(input int d, input logic [13:0] exp, input string name);
    int k;
    k = 0;
    while (!out_valid_o[d] && k < 100) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (!out_valid_o[d]) $display("FAIL %s timeout: out_valid=0, expected 1", name);
    else if (out_data_o[d] !== exp) $display("FAIL %s: out_data=%0d, expected %0d", name, out_data_o[d], exp);
    else passed++;
    while (out_valid_o[d] && k < 200) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      total++; if (in_ready_o[d] !== 1'b1) $display("FAIL rst_in_ready dut%0d: %0b, expected 1", d, in_ready_o[d]); else passed++;
      total++; if (out_valid_o[d] !== 1'b0) $display("FAIL rst_out_valid dut%0d: %0b, expected 0", d, out_valid_o[d]); else passed++;
      total++; if (out_data_o[d] !== 14'd0) $display("FAIL rst_out_data dut%0d: %0d, expected 0", d, out_data_o[d]); else passed++;
      total++; if (bank_o[d] !== 160'd0) $display("FAIL rst_bank dut%0d: %0h, expected 0", d, bank_o[d]); else passed++;
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_full_frame();
    for (int i = 0; i < 16; i++) put(0, 10'd1023, 1'b0, 0);
    total++; if (out_valid_o[0] !== 1'b0) $display("FAIL full_ov_n: %0b, expected 0", out_valid_o[0]); else passed++;
    total++; if (in_ready_o[0] !== 1'b0) $display("FAIL full_ir_n: %0b, expected 0", in_ready_o[0]); else passed++;
    @(negedge clk);
    total++; if (out_valid_o[0] !== 1'b1) $display("FAIL full_ov_n1: %0b, expected 1", out_valid_o[0]); else passed++;
    total++; if (out_data_o[0] !== 14'd16368) $display("FAIL full_data: %0d, expected 16368", out_data_o[0]); else passed++;
    total++; if (in_ready_o[0] !== 1'b0) $display("FAIL full_ir_n1: %0b, expected 0", in_ready_o[0]); else passed++;
    @(negedge clk);
    total++; if (out_valid_o[0] !== 1'b0) $display("FAIL full_ov_n2: %0b, expected 0", out_valid_o[0]); else passed++;
    total++; if (in_ready_o[0] !== 1'b1) $display("FAIL full_ir_n2: %0b, expected 1", in_ready_o[0]); else passed++;
  endtask

  task automatic test_latency_stall();
    out_ready[1] = 1'b0;
    for (int i = 0; i < 16; i++) put(1, 10'(i), 1'b0, 0);
    for (int c = 0; c < 3; c++) begin
      total++; if (out_valid_o[1] !== 1'b0) $display("FAIL lat_early_c%0d: out_valid=%0b, expected 0", c, out_valid_o[1]); else passed++;
      @(negedge clk);
    end
    total++; if (out_valid_o[1] !== 1'b1) $display("FAIL lat_ov: %0b, expected 1", out_valid_o[1]); else passed++;
    total++; if (out_data_o[1] !== 14'd120) $display("FAIL lat_data: %0d, expected 120", out_data_o[1]); else passed++;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (out_valid_o[1] !== 1'b1 || out_data_o[1] !== 14'd120)
        $display("FAIL stall_c%0d: out_valid=%0b out_data=%0d, expected 1/120", c, out_valid_o[1], out_data_o[1]); else passed++;
      total++; if (in_ready_o[1] !== 1'b0) $display("FAIL stall_ir_c%0d: %0b, expected 0", c, in_ready_o[1]); else passed++;
    end
    out_ready[1] = 1'b1;
    @(negedge clk);
    total++; if (out_valid_o[1] !== 1'b0) $display("FAIL stall_release_ov: %0b, expected 0", out_valid_o[1]); else passed++;
    total++; if (in_ready_o[1] !== 1'b1) $display("FAIL stall_release_ir: %0b, expected 1", in_ready_o[1]); else passed++;
  endtask

  task automatic test_gapped();
    for (int k = 0; k < 16; k++) put(0, 10'(10 * (k + 1)), 1'b0, 1);
    for (int k = 0; k < 16; k++) begin
      total++; if (bank_o[0][10*k +: 10] !== 10'(10 * (k + 1)))
        $display("FAIL gap_slot%0d: %0d, expected %0d", k, bank_o[0][10*k +: 10], 10 * (k + 1)); else passed++;
    end
    wait_out(0, 14'd1360, "gap_sum");
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 7; i++) put(0, 10'd5, 1'b0, 0);
    reset = 1'b1;
    @(negedge clk);
    total++; if (bank_o[0] !== 160'd0) $display("FAIL mid_rst_bank: %0h, expected 0", bank_o[0]); else passed++;
    total++; if (in_ready_o[0] !== 1'b1) $display("FAIL mid_rst_ir: %0b, expected 1", in_ready_o[0]); else passed++;
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) put(0, 10'd2, 1'b0, 0);
    wait_out(0, 14'd32, "mid_rst_sum");
  endtask

  task automatic test_back_to_back();
    out_ready[1] = 1'b1;
    fork
      begin
        for (int i = 0; i < 16; i++) put(1, 10'd3, 1'b0, 0);
        for (int i = 0; i < 16; i++) put(1, 10'd7, 1'b0, 0);
      end
      begin
        wait_out(1, 14'd48, "b2b_a");
        wait_out(1, 14'd112, "b2b_b");
      end
    join
  endtask

  task automatic test_in_last();
    for (int i = 0; i < 16; i++) put(0, 10'd1023, 1'b0, 0);
    wait_out(0, 14'd16368, "last_prefill");
    put(0, 10'd100, 1'b0, 0);
    put(0, 10'd200, 1'b0, 0);
    put(0, 10'd300, 1'b1, 0);
    total++; if (bank_o[0][29:0] !== {10'd300, 10'd200, 10'd100})
      $display("FAIL last_low_slots: %0h, expected %0h", bank_o[0][29:0], {10'd300, 10'd200, 10'd100}); else passed++;
`ifdef AFFINE3_OP2_FEED_ZEROPAD_EN
    total++; if (bank_o[0][159:30] !== 130'd0) $display("FAIL zp_high_slots: %0h, expected 0", bank_o[0][159:30]); else passed++;
    wait_out(0, 14'd600, "zp_sum");
`else
    @(negedge clk);
    total++; if (in_ready_o[0] !== 1'b1 || out_valid_o[0] !== 1'b0)
      $display("FAIL nolast_state: in_ready=%0b out_valid=%0b, expected 1/0", in_ready_o[0], out_valid_o[0]); else passed++;
    total++; if (bank_o[0][159:30] !== {13{10'd1023}}) $display("FAIL nolast_high_slots: %0h, expected all 1023", bank_o[0][159:30]); else passed++;
    for (int i = 0; i < 13; i++) put(0, 10'd0, 1'b0, 0);
    wait_out(0, 14'd600, "nolast_sum");
`endif
  endtask

  initial begin
    in_data[0] = '0;
    in_data[1] = '0;
    test_reset();
    test_full_frame();
    test_latency_stall();
    test_gapped();
    test_reset_mid_frame();
    test_back_to_back();
    test_in_last();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/affine3_op2_feed.md
# affine3_op2_feed

Front-end sequencer for the affine3 second-stage adder. Accepts 10-bit partial products one word per cycle over a valid/ready stream and loads them into a 16-slot register bank that drives the adder's 16 parallel inputs. It then waits out the adder latency, captures the 14-bit sum, and offers the sum downstream on a valid/ready stream. One frame is 16 input words and produces one output word.

## Interface
- ADD_LATENCY, 0: cycles of registered latency inside the external 16-input adder; 0 means purely combinational.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  10  unsigned partial product.
- in_last  input  1  early end of frame; used only with the configuration macro.
- bank_out  output  160  slot i on bits [10i+9:10i]; wired to the adder's 16 data inputs.
- sum_in  input  14  adder result, unsigned.
- out_valid  output  1  out_data holds a captured sum.
- out_ready  input  1  downstream accepts out_data.
- out_data  output  14  captured sum.

## Operation
- A transfer occurs on an edge where in_valid and in_ready are both 1. The same rule applies to out_valid and out_ready.
- The state machine has three states: FILL, WAIT and HOLD.
- **FILL:**
  - in_ready=1.
  - Each transfer writes in_data into slot cnt, then cnt increments (4 bits).
  - The transfer with cnt=15 moves the block to WAIT, loads wcnt=ADD_LATENCY and leaves cnt at 0 (4-bit wrap).
- **WAIT:**
  - in_ready=0 and the bank is frozen.
  - If wcnt≠0, wcnt decrements each cycle.
  - On the edge where wcnt=0, sum_in is registered into out_data, out_valid becomes 1, and the block moves to HOLD.
- **HOLD:**
  - in_ready=0.
  - out_data and out_valid are held stable until a transfer.
  - On the transfer edge: out_valid becomes 0, the block returns to FILL, and in_ready=1 from the next cycle.
- Frames never overlap: input stalls while the result is pending.
- The bank is not cleared between frames. Every slot is overwritten before the next sum is captured.
- Arithmetic: the maximum sum is 16×1023=16368 < 2^14, so no overflow handling is needed. sum_in is taken verbatim.
- in_valid while in_ready=0 is ignored. No data is lost, because the upstream holds the word.
- **Reset, applied at any time including mid-frame:**
  - state=FILL, cnt=0, wcnt=0, all bank slots 0.
  - out_data=0, out_valid=0, in_ready=1.
  - Any partial frame is discarded.

## Timing
- Reset values of outputs: in_ready=1, out_valid=0, out_data=0, bank_out=0.
- Input throughput in FILL is 1 word/cycle with no bubbles.
- Latency, with the 16th input transfer on edge N: out_valid rises after edge N+1+ADD_LATENCY.
- Minimum frame period is 16+1+ADD_LATENCY+1 cycles, with out_ready tied to 1.
- bank_out slot k changes only on the edge of its own transfer, or on a zero-fill edge.
- out_valid is never deasserted without a transfer, except by reset.
- in_ready is a registered function of state. It has no combinational path from out_ready.

## Configuration
- **AFFINE3_OP2_FEED_ZEROPAD_EN defined:**
  - A FILL transfer with in_last=1 writes in_data to slot cnt.
  - On the same edge, all slots cnt+1..15 are written to 0, cnt resets to 0, and the block enters WAIT.
  - in_last on slot 15 is identical to a normal frame end.
  - in_last with cnt=0 yields a 1-word frame.
- **AFFINE3_OP2_FEED_ZEROPAD_EN undefined:**
  - in_last is ignored.
  - Every frame is exactly 16 words.

## Test plan
- **Full frame, ADD_LATENCY=0:**
  - Stimulus: 16 back-to-back words of value 1023, bench adder modelled combinationally, out_ready=1.
  - Required: out_data=16368 with out_valid high exactly one cycle after the 16th transfer, then in_ready=1 on the following cycle.
- **ADD_LATENCY=2 with downstream stall:**
  - Stimulus: words 0..15 (sum 120), bench adder modelled with 2 registers, out_ready=0 for 5 cycles.
  - Required: out_data=120 appears 3 cycles after the last transfer and stays stable with out_valid=1 through the stall. in_ready stays 0 until the cycle after the out handshake.
- **Gapped input:**
  - Stimulus: in_valid toggled 1/0 per cycle, words 10,20,…,160.
  - Required: bank_out slot k=10(k+1) and out_data=1360.
- **Reset mid-frame:**
  - Stimulus: 7 words of 5, then reset pulsed, then 16 words of 2.
  - Required: out_data=32, proving slots were cleared and cnt restarted at 0.
- **Back-to-back frames:**
  - Stimulus: frame A (all 3), then frame B (all 7) presented immediately, out_ready=1.
  - Required: outputs 48 then 112. No input accepted while in WAIT or HOLD.
- **With AFFINE3_OP2_FEED_ZEROPAD_EN, after a frame of all 1023:**
  - Stimulus: 3 words (100, 200, 300), with in_last on the third.
  - Required: slots 3..15 read 0 and out_data=600.
